// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package bit_serial_adder_pkg;

   // Encoding 2'd3 is never entered; the FSM treats it as IDLE on the next edge.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/bit_serial_adder_if.sv
// Request/result bundle of the bit-serial adder; master drives operands, slave is the adder.
interface bit_serial_adder_if #(parameter int DATA_WIDTH = 8);
   logic                  Start_In;
   logic [DATA_WIDTH-1:0] Data_A_In;
   logic [DATA_WIDTH-1:0] Data_B_In;
   logic                  Carry_In;
   logic                  Ready_Out;
   logic                  Busy_Out;
   logic                  Done_Out;
   logic [DATA_WIDTH-1:0] Sum_Out;
   logic                  Carry_Out;

   modport master (
      output Start_In, Data_A_In, Data_B_In, Carry_In,
      input  Ready_Out, Busy_Out, Done_Out, Sum_Out, Carry_Out
   );

   modport slave (
      input  Start_In, Data_A_In, Data_B_In, Carry_In,
      output Ready_Out, Busy_Out, Done_Out, Sum_Out, Carry_Out
   );
endinterface

// File: rtl/bit_serial_adder_cell.sv
// Combinational full adder built from two half-adder stages joined by an OR.
module serial_full_adder_cell (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);
   logic w_p;
   logic w_g;
   logic w_pc;

   assign w_p    = i_a ^ i_b;
   assign w_g    = i_a & i_b;
   assign o_sum  = w_p ^ i_cin;
   assign w_pc   = w_p & i_cin;
   assign o_cout = w_g | w_pc;
endmodule

// File: rtl/bit_serial_adder.sv
// Multi-cycle adder: one full-adder cell consumes operands LSB-first, one bit per clock.
module bit_serial_adder
   import bit_serial_adder_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input logic               Clock_In,
   input logic               Reset_In,
   bit_serial_adder_if.slave bus
);
   localparam int CNT_WIDTH = $clog2(DATA_WIDTH + 1);

   state_t                r_state;
   logic [CNT_WIDTH-1:0]  r_count;
   logic [DATA_WIDTH-1:0] r_a;
   logic [DATA_WIDTH-1:0] r_b;
   logic [DATA_WIDTH-1:0] r_sum;
   logic [DATA_WIDTH-1:0] r_sumOut;
   logic                  r_carry;
   logic                  r_carryOut;
   logic                  r_ready;
   logic                  r_busy;
   logic                  r_done;

   logic                  w_bitSum;
   logic                  w_bitCarry;
   logic                  w_lastBit;
   logic [DATA_WIDTH-1:0] w_sumNext;

   serial_full_adder_cell u_cell (
      .i_a    (r_a[0]),
      .i_b    (r_b[0]),
      .i_cin  (r_carry),
      .o_sum  (w_bitSum),
      .o_cout (w_bitCarry)
   );

   // New sum bit enters at the MSB so that after DATA_WIDTH shifts bit 0 sits at the LSB.
   always_comb begin
      w_sumNext                 = r_sum >> 1;
      w_sumNext[DATA_WIDTH-1]   = w_bitSum;
   end

   assign w_lastBit = (r_count == CNT_WIDTH'(DATA_WIDTH - 1));

   always_ff @(posedge Clock_In) begin
      if (Reset_In) begin
         r_state    <= ST_IDLE;
         r_count    <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_sum      <= '0;
         r_sumOut   <= '0;
         r_carry    <= 1'b0;
         r_carryOut <= 1'b0;
         r_ready    <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.Start_In) begin
                  r_a     <= bus.Data_A_In;
                  r_b     <= bus.Data_B_In;
                  r_carry <= bus.Carry_In;
                  r_count <= '0;
                  r_state <= ST_SHIFT;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            ST_SHIFT: begin
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_sum   <= w_sumNext;
               r_carry <= w_bitCarry;
               r_count <= r_count + CNT_WIDTH'(1);
               if (w_lastBit) begin
                  r_sumOut   <= w_sumNext;
                  r_carryOut <= w_bitCarry;
                  r_done     <= 1'b1;
                  r_state    <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.Ready_Out = r_ready;
   assign bus.Busy_Out  = r_busy;
   assign bus.Done_Out  = r_done;
   assign bus.Sum_Out   = r_sumOut;
   assign bus.Carry_Out = r_carryOut;
endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder at DATA_WIDTH=8 and DATA_WIDTH=1 against an arithmetic model.
module tb_bit_serial_adder;

   typedef struct {
      logic [8:0] full;
      int         acceptCycle;
   } exp_t;

   logic clk = 1'b0;
   logic rst8;
   logic rst1;

   bit_serial_adder_if #(.DATA_WIDTH(8)) bus8();
   bit_serial_adder_if #(.DATA_WIDTH(1)) bus1();

   bit_serial_adder #(.DATA_WIDTH(8)) dut8 (
      .Clock_In (clk),
      .Reset_In (rst8),
      .bus      (bus8.slave)
   );

   bit_serial_adder #(.DATA_WIDTH(1)) dut1 (
      .Clock_In (clk),
      .Reset_In (rst1),
      .bus      (bus1.slave)
   );

   always #5 clk = ~clk;

   exp_t       expQ[2][$];
   int         modelLeft[2];
   logic [8:0] modelOut[2];
   logic [8:0] curOp[2];
   int         accepts[2];
   int         cycle = 0;
   bit         checking = 1'b0;
   int         errors = 0;
   int         checks = 0;

   task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h at cycle %0d", name, actual, expected, cycle);
      end
   endtask

   // Behavioural model: result is plain A+B+Cin; busy for w+1 edges after an accept.
   task automatic modelStep(int d, int w, logic rst, logic start, logic [7:0] a, logic [7:0] b, logic cin);
      exp_t e;
      if (rst) begin
         modelLeft[d] = 0;
         modelOut[d]  = '0;
         expQ[d].delete();
      end else if (modelLeft[d] == 0) begin
         if (start) begin
            e.full        = 9'(a) + 9'(b) + 9'(cin);
            e.acceptCycle = cycle;
            curOp[d]      = e.full;
            expQ[d].push_back(e);
            modelLeft[d]  = w + 1;
            accepts[d]++;
         end
      end else begin
         modelLeft[d]--;
         if (modelLeft[d] == 1) modelOut[d] = curOp[d];
      end
   endtask

   task automatic monitorStep(int d, int w, logic ready, logic busy, logic done, logic [8:0] res);
      exp_t e;
      checkOutput($sformatf("dut%0d ready", d), 32'(ready), 32'(modelLeft[d] == 0));
      checkOutput($sformatf("dut%0d busy", d), 32'(busy), 32'(modelLeft[d] != 0));
      checkOutput($sformatf("dut%0d done", d), 32'(done), 32'(modelLeft[d] == 1));
      checkOutput($sformatf("dut%0d held result", d), 32'(res), 32'(modelOut[d]));
      if (done) begin
         if (expQ[d].size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL dut%0d unexpected done: actual=done expected=no pending op at cycle %0d", d, cycle);
         end else begin
            e = expQ[d].pop_front();
            checkOutput($sformatf("dut%0d result", d), 32'(res), 32'(e.full));
            checkOutput($sformatf("dut%0d latency", d), 32'(cycle - e.acceptCycle), 32'(w));
         end
      end
   endtask

   always @(posedge clk) begin
      cycle++;
      modelStep(0, 8, rst8, bus8.Start_In, bus8.Data_A_In, bus8.Data_B_In, bus8.Carry_In);
      modelStep(1, 1, rst1, bus1.Start_In, {7'b0, bus1.Data_A_In}, {7'b0, bus1.Data_B_In}, bus1.Carry_In);
   end

   always @(negedge clk) begin
      if (checking) begin
         monitorStep(0, 8, bus8.Ready_Out, bus8.Busy_Out, bus8.Done_Out, {bus8.Carry_Out, bus8.Sum_Out});
         monitorStep(1, 1, bus1.Ready_Out, bus1.Busy_Out, bus1.Done_Out, {7'b0, bus1.Carry_Out, bus1.Sum_Out});
      end
   end

   task automatic driveInputs(int d, logic s, logic [7:0] a, logic [7:0] b, logic c);
      if (d == 0) begin
         bus8.Start_In  = s;
         bus8.Data_A_In = a;
         bus8.Data_B_In = b;
         bus8.Carry_In  = c;
      end else begin
         bus1.Start_In  = s;
         bus1.Data_A_In = a[0];
         bus1.Data_B_In = b[0];
         bus1.Carry_In  = c;
      end
   endtask

   task automatic waitIdle(int d);
      for (int i = 0; i < 40; i++) begin
         if (modelLeft[d] == 0) return;
         @(negedge clk);
      end
      checks++;
      errors++;
      $display("[TB] FAIL dut%0d idle timeout: actual=busy expected=idle within 40 cycles", d);
   endtask

   task automatic applyStimulus(int d, logic [7:0] a, logic [7:0] b, logic c);
      driveInputs(d, 1'b1, a, b, c);
      @(negedge clk);
      driveInputs(d, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
      waitIdle(d);
   endtask

   task automatic randomRun(int d, int w, int n);
      for (int i = 0; i < n; i++) begin
         driveInputs(d, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
         for (int j = 0; j < w + 1 + int'($urandom_range(0, 3)); j++) begin
            @(negedge clk);
            driveInputs(d, ($urandom % 4) == 0, 8'($urandom), 8'($urandom), 1'($urandom));
         end
      end
      @(negedge clk);
      driveInputs(d, 1'b0, 8'h00, 8'h00, 1'b0);
      waitIdle(d);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: actual=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      int doneCycles[$];
      logic [7:0] pairA[3];
      logic [7:0] pairB[3];

      rst8 = 1'b1;
      rst1 = 1'b1;
      driveInputs(0, 1'b0, 8'h00, 8'h00, 1'b0);
      driveInputs(1, 1'b0, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      @(negedge clk);
      checking = 1'b1;
      checkOutput("reset sum", 32'(bus8.Sum_Out), 32'h0);
      checkOutput("reset ready", 32'(bus8.Ready_Out), 32'h1);
      rst8 = 1'b0;
      rst1 = 1'b0;
      @(negedge clk);

      applyStimulus(0, 8'h3C, 8'h5A, 1'b0);
      checkOutput("basic sum", 32'(bus8.Sum_Out), 32'h96);
      checkOutput("basic carry", 32'(bus8.Carry_Out), 32'h0);

      applyStimulus(0, 8'hFF, 8'h01, 1'b0);
      checkOutput("wrap sum", 32'(bus8.Sum_Out), 32'h00);
      checkOutput("wrap carry", 32'(bus8.Carry_Out), 32'h1);
      applyStimulus(0, 8'hFF, 8'h00, 1'b1);
      checkOutput("cin wrap sum", 32'(bus8.Sum_Out), 32'h00);
      checkOutput("cin wrap carry", 32'(bus8.Carry_Out), 32'h1);

      // Start pulse while busy must be ignored.
      driveInputs(0, 1'b1, 8'h3C, 8'h5A, 1'b0);
      @(negedge clk);
      driveInputs(0, 1'b0, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      @(negedge clk);
      driveInputs(0, 1'b1, 8'h11, 8'h11, 1'b0);
      @(negedge clk);
      driveInputs(0, 1'b0, 8'h00, 8'h00, 1'b0);
      waitIdle(0);
      checkOutput("ignored start sum", 32'(bus8.Sum_Out), 32'h96);

      // Reset mid-operation aborts it.
      driveInputs(0, 1'b1, 8'h77, 8'h22, 1'b1);
      @(negedge clk);
      driveInputs(0, 1'b0, 8'h00, 8'h00, 1'b0);
      repeat (3) @(negedge clk);
      rst8 = 1'b1;
      @(negedge clk);
      rst8 = 1'b0;
      checkOutput("abort sum", 32'(bus8.Sum_Out), 32'h0);
      checkOutput("abort ready", 32'(bus8.Ready_Out), 32'h1);
      checkOutput("abort busy", 32'(bus8.Busy_Out), 32'h0);
      repeat (12) @(negedge clk);

      // Start held high: back-to-back accepts, operands switched after each accept.
      pairA = '{8'h12, 8'hF0, 8'h80};
      pairB = '{8'h34, 8'h20, 8'h80};
      base = accepts[0];
      driveInputs(0, 1'b1, pairA[0], pairB[0], 1'b0);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus8.Done_Out) doneCycles.push_back(cycle);
         if (accepts[0] - base >= 3) driveInputs(0, 1'b0, 8'h00, 8'h00, 1'b0);
         else driveInputs(0, 1'b1, pairA[accepts[0] - base], pairB[accepts[0] - base], 1'b1);
      end
      checkOutput("held start done count", 32'(doneCycles.size()), 32'd3);
      if (doneCycles.size() == 3) begin
         checkOutput("done spacing 1", 32'(doneCycles[1] - doneCycles[0]), 32'd10);
         checkOutput("done spacing 2", 32'(doneCycles[2] - doneCycles[1]), 32'd10);
      end
      waitIdle(0);

      randomRun(0, 8, 30);

      for (int k = 0; k < 8; k++) begin
         applyStimulus(1, 8'(k & 1), 8'((k >> 1) & 1), 1'((k >> 2) & 1));
         checkOutput($sformatf("w1 combo %0d", k), 32'({bus1.Carry_Out, bus1.Sum_Out}),
                     32'((k & 1) + ((k >> 1) & 1) + ((k >> 2) & 1)));
      end
      randomRun(1, 1, 30);

      @(negedge clk);
      checkOutput("dut0 queue drained", 32'(expQ[0].size()), 32'd0);
      checkOutput("dut1 queue drained", 32'(expQ[1].size()), 32'd0);
      checking = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
